link_ctrl: RTL

LINK_CTRL -- requirements
Module: link_ctrl

---
 rtl/link_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/link_ctrl.sv
// Link-register controller: keeps return addresses in LR with a small spill stack behind it.
// Optional macro LINK_CTRL_OVF_WRAP_EN: a push into a full stack overwrites the oldest entry instead of being dropped.
module link_ctrl #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     call_req,
  input  logic                     ret_req,
  input  logic [W-1:0]             ret_pc,
  input  logic [W-1:0]             lr_q,
  output logic [W-1:0]             lr_in,
  output logic                     lr_en,
  output logic                     tgt_valid,
  output logic [W-1:0]             tgt_addr,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     ovf_err,
  output logic                     unf_err
);

  localparam int unsigned SPW = $clog2(DEPTH);
  localparam int unsigned DW  = SPW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [SPW-1:0] sp_q;
  logic [DW-1:0]  depth_q;
  logic           lr_live_q;
  logic [W-1:0]   pc_lat_q;
  logic [W-1:0]   stack_q [DEPTH];

  logic push_c, pop_c, live_set_c, live_clr_c, ovf_set_c, unf_set_c, lat_en_c;
  logic full_c;

  assign full_c  = (depth_q == DW'(DEPTH));
  assign depth   = depth_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, combinational outputs and datapath strobes; everything is forced low during reset
  always_comb begin
    state_d    = state_q;
    lr_in      = '0;
    lr_en      = 1'b0;
    tgt_valid  = 1'b0;
    tgt_addr   = '0;
    stall      = 1'b0;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    live_set_c = 1'b0;
    live_clr_c = 1'b0;
    ovf_set_c  = 1'b0;
    unf_set_c  = 1'b0;
    lat_en_c   = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          // A return wins over a simultaneous call
          if (ret_req) begin
            if (lr_live_q) begin
              tgt_valid = 1'b1;
              tgt_addr  = lr_q;
              if (depth_q != '0) begin
                state_d = POP;
              end else begin
                live_clr_c = 1'b1;
              end
            end else begin
              unf_set_c = 1'b1;
            end
          end else if (call_req) begin
            if (!lr_live_q) begin
              lr_in      = ret_pc;
              lr_en      = 1'b1;
              live_set_c = 1'b1;
            end else begin
              stall    = 1'b1;
              lat_en_c = 1'b1;
              state_d  = PUSH;
            end
          end
        end
        PUSH: begin
          lr_in     = pc_lat_q;
          lr_en     = 1'b1;
          push_c    = 1'b1;
          ovf_set_c = full_c;
          state_d   = IDLE;
        end
        POP: begin
          lr_in   = stack_q[sp_q - SPW'(1)];
          lr_en   = 1'b1;
          stall   = 1'b1;
          pop_c   = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Spill stack, pointers, live flag and sticky errors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q      <= '0;
      depth_q   <= '0;
      lr_live_q <= 1'b0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
      pc_lat_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      if (lat_en_c) begin
        pc_lat_q <= ret_pc;
      end
      if (live_set_c) begin
        lr_live_q <= 1'b1;
      end else if (live_clr_c) begin
        lr_live_q <= 1'b0;
      end
      if (unf_set_c) begin
        unf_err <= 1'b1;
      end
      if (ovf_set_c) begin
        ovf_err <= 1'b1;
      end
      if (push_c) begin
        if (!full_c) begin
          stack_q[sp_q] <= lr_q;
          sp_q          <= sp_q + SPW'(1);
          depth_q       <= depth_q + DW'(1);
        end else begin
`ifdef LINK_CTRL_OVF_WRAP_EN
          // Oldest entry sits at sp when full; overwrite it and keep depth pinned
          stack_q[sp_q] <= lr_q;
          sp_q          <= sp_q + SPW'(1);
`else
          sp_q          <= sp_q;
`endif
        end
      end
      if (pop_c && (depth_q != '0)) begin
        sp_q    <= sp_q - SPW'(1);
        depth_q <= depth_q - DW'(1);
      end
    end
  end

endmodule
